// File: rtl/syn_gpu_pkg.sv
// Shared GPU definitions: job action field, job word width and job queue defaults.
package syn_gpu_pkg;

  typedef enum logic [1:0] {
    ACT_NOP   = 2'd0,
    ACT_DRAW  = 2'd1,
    ACT_CLEAR = 2'd2,
    ACT_AA    = 2'd3
  } action_t;

  localparam int P_GPU_JOB_BFFR_W   = 10;
  localparam int P_GPU_JOB_Q_NUM_CH = 2;
  localparam int P_GPU_JOB_Q_DEPTH  = 8;

  // The action field sits in the top two bits of a job word.
  function automatic action_t get_job_action(input logic [P_GPU_JOB_BFFR_W-1:0] job);
    return action_t'(job[P_GPU_JOB_BFFR_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/syn_gpu_job_queue_if.sv
// Enqueue, status and dispatch signals of syn_gpu_job_queue; slave = queue side.
interface syn_gpu_job_queue_if #(
  parameter int P_NUM_CH = syn_gpu_pkg::P_GPU_JOB_Q_NUM_CH,
  parameter int P_DEPTH  = syn_gpu_pkg::P_GPU_JOB_Q_DEPTH,
  parameter int P_JOB_W  = syn_gpu_pkg::P_GPU_JOB_BFFR_W
);
  localparam int OCC_W = $clog2(P_DEPTH + 1);
  localparam int CH_W  = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;

  logic [P_NUM_CH-1:0]         wr_en_i;
  logic [P_NUM_CH*P_JOB_W-1:0] wr_job_i;
  logic [P_NUM_CH-1:0]         flush_i;
  logic [P_NUM_CH-1:0]         full_o;
  logic [P_NUM_CH-1:0]         empty_o;
  logic [P_NUM_CH*OCC_W-1:0]   occ_o;
  logic [P_NUM_CH-1:0]         ovrflw_o;
  logic                        job_valid_o;
  logic                        job_ready_i;
  logic [P_JOB_W-1:0]          job_data_o;
  logic [1:0]                  job_action_o;
  logic [CH_W-1:0]             job_ch_o;

  modport master (
    output wr_en_i, wr_job_i, flush_i, job_ready_i,
    input  full_o, empty_o, occ_o, ovrflw_o, job_valid_o, job_data_o, job_action_o, job_ch_o
  );

  modport slave (
    input  wr_en_i, wr_job_i, flush_i, job_ready_i,
    output full_o, empty_o, occ_o, ovrflw_o, job_valid_o, job_data_o, job_action_o, job_ch_o
  );

endinterface

// File: rtl/syn_gpu_job_rr_arb.sv
// Combinational channel arbiter: strict lowest-index or round-robin after last grant.
module syn_gpu_job_rr_arb #(
  parameter int P_NUM_CH = 2,
  parameter int CH_W     = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1
) (
  input  logic [P_NUM_CH-1:0] req_i,
  input  logic                rr_en_i,
  input  logic [CH_W-1:0]     last_i,
  output logic [P_NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]     idx_o,
  output logic                vld_o
);

  logic [CH_W-1:0] c;

  // Scan order starts at channel 0 (strict) or just after last_i (round-robin).
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < P_NUM_CH; k++) begin
      if (rr_en_i) c = CH_W'((32'(last_i) + 32'd1 + k) % P_NUM_CH);
      else         c = CH_W'(k);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        idx_o    = c;
        gnt_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syn_gpu_job_queue.sv
// Multi-channel circular job FIFOs feeding one registered dispatch port.
// Optional SYN_GPU_JOB_QUEUE_STATS_EN adds saturating drop/dispatch counters.
module syn_gpu_job_queue
  import syn_gpu_pkg::*;
#(
  parameter int P_NUM_CH = P_GPU_JOB_Q_NUM_CH,
  parameter int P_DEPTH  = P_GPU_JOB_Q_DEPTH,
  parameter int P_JOB_W  = P_GPU_JOB_BFFR_W
) (
  input  logic        clk_ir,
  input  logic        rst_ih,
  input  logic        cfg_rr_en_i,
`ifdef SYN_GPU_JOB_QUEUE_STATS_EN
  input  logic        stat_clr_i,
  output logic [15:0] stat_drop_cnt_o,
  output logic [15:0] stat_disp_cnt_o,
`endif
  syn_gpu_job_queue_if.slave q_if
);

  localparam int PTR_W = $clog2(P_DEPTH);
  localparam int OCC_W = $clog2(P_DEPTH + 1);
  localparam int CH_W  = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;

  logic [P_JOB_W-1:0] mem_q  [P_NUM_CH][P_DEPTH];
  logic [PTR_W-1:0]   wptr_q [P_NUM_CH];
  logic [PTR_W-1:0]   wptr_d [P_NUM_CH];
  logic [PTR_W-1:0]   rptr_q [P_NUM_CH];
  logic [PTR_W-1:0]   rptr_d [P_NUM_CH];
  logic [OCC_W-1:0]   occ_q  [P_NUM_CH];
  logic [OCC_W-1:0]   occ_d  [P_NUM_CH];

  logic [P_NUM_CH-1:0] full, empty, req, wr_ok, deq, gnt;
  logic [P_NUM_CH-1:0] ovrflw_q, ovrflw_d;
  logic [CH_W-1:0]     gnt_idx, last_q, ch_q;
  logic                gnt_vld, load;
  logic                valid_q;
  logic [P_JOB_W-1:0]  data_q;

  // Flush masks a channel from write, overflow and grant in the same cycle.
  always_comb begin
    for (int unsigned c = 0; c < P_NUM_CH; c++) begin
      full[c]     = (occ_q[c] == OCC_W'(P_DEPTH));
      empty[c]    = (occ_q[c] == '0);
      req[c]      = !empty[c] && !q_if.flush_i[c];
      wr_ok[c]    = q_if.wr_en_i[c] && !full[c] && !q_if.flush_i[c];
      ovrflw_d[c] = q_if.wr_en_i[c] && full[c] && !q_if.flush_i[c];
    end
  end

  syn_gpu_job_rr_arb #(
    .P_NUM_CH (P_NUM_CH),
    .CH_W     (CH_W)
  ) u_arb (
    .req_i   (req),
    .rr_en_i (cfg_rr_en_i),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .vld_o   (gnt_vld)
  );

  assign load = (!valid_q || q_if.job_ready_i) && gnt_vld;
  assign deq  = load ? gnt : '0;

  always_comb begin
    for (int unsigned c = 0; c < P_NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      occ_d[c]  = occ_q[c];
      if (q_if.flush_i[c]) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
        occ_d[c]  = '0;
      end else begin
        if (wr_ok[c]) wptr_d[c] = wptr_q[c] + PTR_W'(1);
        if (deq[c])   rptr_d[c] = rptr_q[c] + PTR_W'(1);
        if (wr_ok[c] && !deq[c])      occ_d[c] = occ_q[c] + OCC_W'(1);
        else if (!wr_ok[c] && deq[c]) occ_d[c] = occ_q[c] - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      for (int unsigned c = 0; c < P_NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
      end
      ovrflw_q <= '0;
    end else begin
      for (int unsigned c = 0; c < P_NUM_CH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
      end
      ovrflw_q <= ovrflw_d;
    end
  end

  always_ff @(posedge clk_ir) begin
    for (int unsigned c = 0; c < P_NUM_CH; c++) begin
      if (wr_ok[c]) mem_q[c][wptr_q[c]] <= q_if.wr_job_i[c*P_JOB_W +: P_JOB_W];
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= CH_W'(P_NUM_CH - 1);
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= mem_q[gnt_idx][rptr_q[gnt_idx]];
      ch_q    <= gnt_idx;
      last_q  <= gnt_idx;
    end else if (q_if.job_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < P_NUM_CH; g++) begin : g_occ
    assign q_if.occ_o[g*OCC_W +: OCC_W] = occ_q[g];
  end

  assign q_if.full_o       = full;
  assign q_if.empty_o      = empty;
  assign q_if.ovrflw_o     = ovrflw_q;
  assign q_if.job_valid_o  = valid_q;
  assign q_if.job_data_o   = data_q;
  assign q_if.job_action_o = data_q[P_JOB_W-1 -: 2];
  assign q_if.job_ch_o     = ch_q;

`ifdef SYN_GPU_JOB_QUEUE_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, disp_cnt_q, disp_cnt_d;
  logic [16:0] drop_sum, disp_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(ovrflw_d));
  assign disp_sum = {1'b0, disp_cnt_q} + 17'(valid_q && q_if.job_ready_i);

  always_comb begin
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
    disp_cnt_d = disp_sum[16] ? '1 : disp_sum[15:0];
    if (stat_clr_i) begin
      drop_cnt_d = '0;
      disp_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      drop_cnt_q <= '0;
      disp_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end

  assign stat_drop_cnt_o = drop_cnt_q;
  assign stat_disp_cnt_o = disp_cnt_q;
`endif

endmodule
